// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcode/ALUOp encodings, control-bundle layouts and the opcode decode table
// used by the pipelined MIPS control unit.
package pipe_ctrl_unit_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SLT   = 3'b100,
    ALU_FUNCT = 3'b101
  } aluop_e;

  localparam int ALUOP_BASE_W = 3;
  localparam int M_W          = 3;
  localparam int WB_W         = 2;
  localparam int EX_REGDST    = 0;
  localparam int M_MEMREAD    = 1;

  typedef struct packed {
    logic   alusrc;
    aluop_e aluop;
    logic   regdst;
  } ex_fields_t;

  typedef struct packed {
    logic memwrite;
    logic memread;
    logic branch;
  } m_t;

  // memtoreg = 1 selects the ALU result
  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_t;

  typedef struct packed {
    ex_fields_t ex;
    m_t         m;
    wb_t        wb;
    logic       legal;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.ex.regdst   = 1'b1;
        d.ex.aluop    = ALU_FUNCT;
        d.wb.regwrite = 1'b1;
        d.wb.memtoreg = 1'b1;
      end
      OP_LW: begin
        d.ex.alusrc   = 1'b1;
        d.ex.aluop    = ALU_ADD;
        d.m.memread   = 1'b1;
        d.wb.regwrite = 1'b1;
      end
      OP_SW: begin
        d.ex.alusrc   = 1'b1;
        d.ex.aluop    = ALU_ADD;
        d.m.memwrite  = 1'b1;
      end
      OP_BEQ: begin
        d.ex.aluop    = ALU_SUB;
        d.m.branch    = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        d.ex.alusrc   = 1'b1;
        d.wb.regwrite = 1'b1;
        d.wb.memtoreg = 1'b1;
        case (op)
          OP_SLTI: d.ex.aluop = ALU_SLT;
          OP_ANDI: d.ex.aluop = ALU_AND;
          OP_ORI:  d.ex.aluop = ALU_OR;
          default: d.ex.aluop = ALU_ADD;
        endcase
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode -> EX/M/WB bundles; zero latency, no backpressure.
// Unknown opcodes produce an all-zero bubble and raise illegal.
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [5:0]         op,
  output logic [ALUOP_W+1:0] ex,
  output logic [M_W-1:0]     m,
  output logic [WB_W-1:0]    wb,
  output logic               illegal
);

  dec_t d;

  always_comb begin
    d       = decode_op(op);
    ex      = '0;
    ex[EX_REGDST]  = d.ex.regdst;
    ex[ALUOP_W:1]  = ALUOP_W'(d.ex.aluop);
    ex[ALUOP_W+1]  = d.ex.alusrc;
    m       = d.m;
    wb      = d.wb;
    illegal = ~d.legal;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: decode in ID, ctrl in EX/MEM/WB at +1/+2/+3 cycles.
// Load-use stalls freeze PC and IF/ID for one cycle; taken branch in MEM flushes IF/ID, ID/EX, EX/MEM.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int ALUOP_W   = 3,
  parameter int REG_AW    = 5,
  parameter int HAZARD_EN = 1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_id,
  input  logic [REG_AW-1:0]   rs_id,
  input  logic [REG_AW-1:0]   rt_id,
  input  logic [REG_AW-1:0]   rd_id,
  input  logic                br_taken_mem,
  output logic [ALUOP_W+1:0]  ex_ctrl,
  output logic [2:0]          m_ctrl,
  output logic [1:0]          wb_ctrl,
  output logic [REG_AW-1:0]   wreg_mem,
  output logic [REG_AW-1:0]   wreg_wb,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                illegal_op,
  output logic [ERRCNT_W-1:0] illegal_cnt
);

  localparam int EX_W = ALUOP_W + 2;

  logic [EX_W-1:0]     dec_ex;
  logic [M_W-1:0]      dec_m;
  logic [WB_W-1:0]     dec_wb;

  logic [EX_W-1:0]     idex_ex;
  logic [M_W-1:0]      idex_m;
  logic [WB_W-1:0]     idex_wb;
  logic [REG_AW-1:0]   idex_rt;
  logic [REG_AW-1:0]   idex_rd;

  logic [M_W-1:0]      exmem_m;
  logic [WB_W-1:0]     exmem_wb;
  logic [REG_AW-1:0]   exmem_wreg;

  logic [WB_W-1:0]     memwb_wb;
  logic [REG_AW-1:0]   memwb_wreg;

  logic [ERRCNT_W-1:0] err_cnt;

  logic                stall;
  logic                flush;
  logic                idex_bubble;
  logic [REG_AW-1:0]   ex_wreg;

  ctrl_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .op      (op_id),
    .ex      (dec_ex),
    .m       (dec_m),
    .wb      (dec_wb),
    .illegal (illegal_op)
  );

  // Load in EX whose destination is read by the instruction in ID; $0 never hazards.
  always_comb begin
    stall = 1'b0;
    if (HAZARD_EN != 0) begin
      stall = idex_m[M_MEMREAD] && (idex_rt != '0) &&
              ((idex_rt == rs_id) || (idex_rt == rt_id));
    end
  end

  assign flush       = br_taken_mem;
  assign idex_bubble = stall || flush;
  assign ex_wreg     = idex_ex[EX_REGDST] ? idex_rd : idex_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ex <= '0;
      idex_m  <= '0;
      idex_wb <= '0;
      idex_rt <= '0;
      idex_rd <= '0;
    end else if (idex_bubble || illegal_op) begin
      // illegal ops also clear the register fields so their wreg reads as 0
      idex_ex <= '0;
      idex_m  <= '0;
      idex_wb <= '0;
      idex_rt <= '0;
      idex_rd <= '0;
    end else begin
      idex_ex <= dec_ex;
      idex_m  <= dec_m;
      idex_wb <= dec_wb;
      idex_rt <= rt_id;
      idex_rd <= rd_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_m    <= '0;
      exmem_wb   <= '0;
      exmem_wreg <= '0;
    end else if (flush) begin
      exmem_m    <= '0;
      exmem_wb   <= '0;
      exmem_wreg <= '0;
    end else begin
      exmem_m    <= idex_m;
      exmem_wb   <= idex_wb;
      exmem_wreg <= ex_wreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_wb   <= '0;
      memwb_wreg <= '0;
    end else begin
      memwb_wb   <= exmem_wb;
      memwb_wreg <= exmem_wreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (illegal_op && !idex_bubble && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  // Flush wins over stall: the stalled instruction is on the wrong path anyway.
  assign pc_write    = !rst && (flush || !stall);
  assign ifid_write  = !rst && (flush || !stall);
  assign ifid_flush  = !rst && flush;

  assign ex_ctrl     = idex_ex;
  assign m_ctrl      = exmem_m;
  assign wb_ctrl     = memwb_wb;
  assign wreg_mem    = exmem_wreg;
  assign wreg_wb     = memwb_wreg;
  assign illegal_cnt = err_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench: cycle-by-cycle vector table plus hand sequences for stall, flush, saturation, reset.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [5:0] op_id;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       br_taken_mem;

  logic [4:0] ex_ctrl, n_ex_ctrl;
  logic [2:0] m_ctrl, n_m_ctrl;
  logic [1:0] wb_ctrl, n_wb_ctrl;
  logic [4:0] wreg_mem, wreg_wb, n_wreg_mem, n_wreg_wb;
  logic       pc_write, ifid_write, ifid_flush, illegal_op;
  logic       n_pc_write, n_ifid_write, n_ifid_flush, n_illegal_op;
  logic [7:0] illegal_cnt, n_illegal_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .HAZARD_EN(1), .ERRCNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .br_taken_mem(br_taken_mem), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
    .wreg_mem(wreg_mem), .wreg_wb(wreg_wb), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
  );

  pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .HAZARD_EN(0), .ERRCNT_W(8)) u_nohz (
    .clk(clk), .rst(rst), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .br_taken_mem(br_taken_mem), .ex_ctrl(n_ex_ctrl), .m_ctrl(n_m_ctrl), .wb_ctrl(n_wb_ctrl),
    .wreg_mem(n_wreg_mem), .wreg_wb(n_wreg_wb), .pc_write(n_pc_write),
    .ifid_write(n_ifid_write), .ifid_flush(n_ifid_flush), .illegal_op(n_illegal_op),
    .illegal_cnt(n_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       br;
    logic [4:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] wmem, wwb;
    logic       pcw, ifw, fl, ill;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic b);
    op_id = o; rs_id = s; rt_id = t; rd_id = d; br_taken_mem = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op, rs, rt, rd, br | ex, m, wb, wmem, wwb, pcw, ifw, fl, ill, cnt
    tbl[0]  = '{6'h00, 5'd1, 5'd2,  5'd5, 1'b0, 5'h00, 3'd0, 2'd0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{6'h00, 5'd0, 5'd0,  5'd0, 1'b0, 5'h0B, 3'd0, 2'd0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{6'h00, 5'd0, 5'd0,  5'd0, 1'b0, 5'h0B, 3'd0, 2'd0, 5'd5,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{6'h23, 5'd1, 5'd4,  5'd0, 1'b0, 5'h0B, 3'd0, 2'd3, 5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{6'h00, 5'd4, 5'd6,  5'd7, 1'b0, 5'h10, 3'd0, 2'd3, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{6'h00, 5'd4, 5'd6,  5'd7, 1'b0, 5'h00, 3'd2, 2'd3, 5'd4,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{6'h08, 5'd2, 5'd8,  5'd0, 1'b0, 5'h0B, 3'd0, 2'd1, 5'd0,  5'd4,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{6'h0A, 5'd0, 5'd9,  5'd0, 1'b0, 5'h10, 3'd0, 2'd0, 5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{6'h0C, 5'd0, 5'd10, 5'd0, 1'b0, 5'h18, 3'd0, 2'd3, 5'd8,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{6'h0D, 5'd0, 5'd11, 5'd0, 1'b0, 5'h14, 3'd0, 2'd3, 5'd9,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{6'h2B, 5'd1, 5'd3,  5'd0, 1'b0, 5'h16, 3'd0, 2'd3, 5'd10, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{6'h04, 5'd1, 5'd2,  5'd0, 1'b0, 5'h10, 3'd0, 2'd3, 5'd11, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{6'h3F, 5'd0, 5'd0,  5'd0, 1'b0, 5'h02, 3'd4, 2'd3, 5'd3,  5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{6'h00, 5'd0, 5'd0,  5'd0, 1'b0, 5'h00, 3'd1, 2'd0, 5'd2,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[14] = '{6'h23, 5'd0, 5'd0,  5'd0, 1'b0, 5'h0B, 3'd0, 2'd0, 5'd0,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[15] = '{6'h00, 5'd0, 5'd0,  5'd1, 1'b0, 5'h10, 3'd0, 2'd0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

    // Reset state (flush input raised to show it is masked during reset)
    rst = 1'b1;
    drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b1);
    #2;
    chk("rst ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst wb_ctrl", 32'(wb_ctrl), 32'h0);
    chk("rst pc_write", 32'(pc_write), 32'h0);
    chk("rst ifid_write", 32'(ifid_write), 32'h0);
    chk("rst ifid_flush", 32'(ifid_flush), 32'h0);
    chk("rst illegal_cnt", 32'(illegal_cnt), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    br_taken_mem = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
      chk($sformatf("row%0d ex_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].ex));
      chk($sformatf("row%0d m_ctrl", i), 32'(m_ctrl), 32'(tbl[i].m));
      chk($sformatf("row%0d wb_ctrl", i), 32'(wb_ctrl), 32'(tbl[i].wb));
      chk($sformatf("row%0d wreg_mem", i), 32'(wreg_mem), 32'(tbl[i].wmem));
      chk($sformatf("row%0d wreg_wb", i), 32'(wreg_wb), 32'(tbl[i].wwb));
      chk($sformatf("row%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
      chk($sformatf("row%0d ifid_write", i), 32'(ifid_write), 32'(tbl[i].ifw));
      chk($sformatf("row%0d ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
      chk($sformatf("row%0d illegal_op", i), 32'(illegal_op), 32'(tbl[i].ill));
      chk($sformatf("row%0d illegal_cnt", i), 32'(illegal_cnt), 32'(tbl[i].cnt));
      tick();
    end

    // Load-use with hazard detection disabled on the second instance
    drive(6'h23, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'h00, 5'd4, 5'd6, 5'd7, 1'b0);
    chk("hz pc_write", 32'(pc_write), 32'h0);
    chk("hz ifid_write", 32'(ifid_write), 32'h0);
    chk("nohz pc_write", 32'(n_pc_write), 32'h1);
    chk("nohz ifid_write", 32'(n_ifid_write), 32'h1);
    tick();
    chk("hz bubble ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("nohz add ex_ctrl", 32'(n_ex_ctrl), 32'h0B);
    drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // Branch flush coincident with a load-use stall
    drive(6'h23, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'h00, 5'd4, 5'd6, 5'd7, 1'b1);
    chk("flush ifid_flush", 32'(ifid_flush), 32'h1);
    chk("flush pc_write", 32'(pc_write), 32'h1);
    chk("flush ifid_write", 32'(ifid_write), 32'h1);
    tick();
    drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("flush ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("flush m_ctrl", 32'(m_ctrl), 32'h0);
    chk("flush wreg_mem", 32'(wreg_mem), 32'h0);
    tick();

    // Asynchronous reset in the middle of a stall
    drive(6'h23, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'h00, 5'd4, 5'd6, 5'd7, 1'b0);
    chk("pre-rst stall pc_write", 32'(pc_write), 32'h0);
    #1;
    rst = 1'b1;
    br_taken_mem = 1'b1;
    #1;
    chk("arst ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("arst m_ctrl", 32'(m_ctrl), 32'h0);
    chk("arst wb_ctrl", 32'(wb_ctrl), 32'h0);
    chk("arst wreg_mem", 32'(wreg_mem), 32'h0);
    chk("arst wreg_wb", 32'(wreg_wb), 32'h0);
    chk("arst pc_write", 32'(pc_write), 32'h0);
    chk("arst ifid_write", 32'(ifid_write), 32'h0);
    chk("arst ifid_flush", 32'(ifid_flush), 32'h0);
    chk("arst illegal_cnt", 32'(illegal_cnt), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    drive(6'h23, 5'd1, 5'd4, 5'd0, 1'b0);
    chk("post-rst pc_write", 32'(pc_write), 32'h1);
    chk("post-rst ex_ctrl", 32'(ex_ctrl), 32'h0);
    tick();
    drive(6'h08, 5'd2, 5'd5, 5'd0, 1'b0);
    chk("post-rst addi pc_write", 32'(pc_write), 32'h1);
    chk("post-rst lw ex_ctrl", 32'(ex_ctrl), 32'h10);
    tick();
    drive(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("post-rst addi ex_ctrl", 32'(ex_ctrl), 32'h10);
    chk("post-rst lw m_ctrl", 32'(m_ctrl), 32'h2);
    chk("post-rst lw wreg_mem", 32'(wreg_mem), 32'h4);
    tick();
    chk("post-rst lw wb_ctrl", 32'(wb_ctrl), 32'h1);
    chk("post-rst lw wreg_wb", 32'(wreg_wb), 32'h4);
    chk("post-rst addi wreg_mem", 32'(wreg_mem), 32'h5);

    // Illegal opcode stream: counter saturates at all-ones
    drive(6'h3F, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("ill illegal_op", 32'(illegal_op), 32'h1);
    for (int k = 0; k < 254; k++) tick();
    chk("ill cnt 254", 32'(illegal_cnt), 32'd254);
    for (int k = 0; k < 46; k++) tick();
    chk("ill cnt sat", 32'(illegal_cnt), 32'd255);
    chk("ill ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("ill m_ctrl", 32'(m_ctrl), 32'h0);
    chk("ill wb_ctrl", 32'(wb_ctrl), 32'h0);
    chk("ill wreg_wb", 32'(wreg_wb), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
